// File: rtl/trojan_seq_param_pkg.sv
// Shared types and helpers for the parametrised sequential key-path trojan.
// Pure declarations; no logic, no latency.
package trojan_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam int         DEF_KEY_W    = 56;
  localparam logic [5:0] DEF_TRIG_SEQ = 6'b10_01_11;

  // Bits needed to hold values 0..max_val, never less than one bit.
  function automatic int cnt_w(input int max_val);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) <= max_val) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/trojan_seq_param_hist.sv
// Symbol history shift register with fill counter and sequence compare.
// History updates on the sampling edge; match is combinational from registered state.
module trojan_seq_hist
  import trojan_pkg::*;
#(
  parameter int                         SYM_W    = 2,
  parameter int                         SEQ_LEN  = 3,
  parameter logic [SEQ_LEN*SYM_W-1:0]   TRIG_SEQ = DEF_TRIG_SEQ
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       vld,
  input  logic [SYM_W-1:0]           sym,
  output logic [SEQ_LEN*SYM_W-1:0]   hist,
  output logic                       match
);

  localparam int HW   = SEQ_LEN * SYM_W;
  localparam int HC_W = cnt_w(SEQ_LEN);

  logic [HC_W-1:0] hist_cnt;
  logic            new_q;
  logic [HW-1:0]   hist_d;

  generate
    if (SEQ_LEN == 1) begin : g_one
      assign hist_d = sym;
    end else begin : g_shift
      assign hist_d = {hist[HW-SYM_W-1:0], sym};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist     <= '0;
      hist_cnt <= '0;
      new_q    <= 1'b0;
    end else begin
      new_q <= vld;
      // A clear drops any symbol sampled on the same edge so re-arming needs a full sequence.
      if (clr) begin
        hist     <= '0;
        hist_cnt <= '0;
      end else if (vld) begin
        hist <= hist_d;
        if (hist_cnt != HC_W'(SEQ_LEN)) hist_cnt <= hist_cnt + 1'b1;
      end
    end
  end

  // new_q keeps a frozen history from being counted again on idle cycles.
  assign match = new_q && (hist_cnt == HC_W'(SEQ_LEN)) && (hist == TRIG_SEQ);

endmodule

// File: rtl/trojan_seq_param.sv
// Inline key-path trojan: arms after TRIG_SEQ is seen COUNT_THRESH times, then XORs FLIP_MASK into the key.
// Payload is registered (1 cycle); optional debug ports/disarm under TROJAN_SEQ_DBG_EN.
module trojan_seq_param
  import trojan_pkg::*;
#(
  parameter int                        KEY_W         = DEF_KEY_W,
  parameter int                        TRIG_W        = 32,
  parameter int                        SYM_W         = 2,
  parameter int                        SEQ_LEN       = 3,
  parameter logic [SEQ_LEN*SYM_W-1:0]  TRIG_SEQ      = DEF_TRIG_SEQ,
  parameter int                        COUNT_THRESH  = 1,
  parameter int                        ACTIVE_CYCLES = 0,
  parameter logic [KEY_W-1:0]          FLIP_MASK     = {{(KEY_W-1){1'b0}}, 1'b1}
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [KEY_W-1:0]                   key,
  input  logic [TRIG_W-1:0]                  trigger,
  input  logic                               trig_valid,
  output logic [KEY_W-1:0]                   payload,
`ifdef TROJAN_SEQ_DBG_EN
  input  logic                               dbg_disarm,
  output logic [cnt_w(COUNT_THRESH)-1:0]     dbg_match_cnt,
  output logic [SEQ_LEN*SYM_W-1:0]           dbg_hist,
`endif
  output logic                               active
);

  localparam int MC_W = cnt_w(COUNT_THRESH);
  localparam int AC_W = cnt_w(ACTIVE_CYCLES);

  state_t                     state, state_d;
  logic [MC_W-1:0]            match_cnt, match_cnt_d;
  logic [AC_W-1:0]            act_cnt, act_cnt_d;
  logic                       hist_clr;
  logic                       match;
  logic [SEQ_LEN*SYM_W-1:0]   hist;

  trojan_seq_hist #(
    .SYM_W    (SYM_W),
    .SEQ_LEN  (SEQ_LEN),
    .TRIG_SEQ (TRIG_SEQ)
  ) u_hist (
    .clk   (clk),
    .rst   (rst),
    .clr   (hist_clr),
    .vld   (trig_valid),
    .sym   (trigger[SYM_W-1:0]),
    .hist  (hist),
    .match (match)
  );

  generate
    if (SYM_W < TRIG_W) begin : g_trig_rest
      logic unused_trig;
      assign unused_trig = ^trigger[TRIG_W-1:SYM_W];
    end
  endgenerate

  always_comb begin
    state_d     = state;
    match_cnt_d = match_cnt;
    act_cnt_d   = act_cnt;
    hist_clr    = 1'b0;
    case (state)
      IDLE: begin
        if (match) begin
          if (MC_W'(match_cnt + 1'b1) == MC_W'(COUNT_THRESH)) begin
            state_d     = ACTIVE;
            match_cnt_d = '0;
          end else begin
            match_cnt_d = match_cnt + 1'b1;
          end
        end
      end
      ACTIVE: begin
        // Matches are ignored here; on expiry a coincident match is simply lost.
        if (ACTIVE_CYCLES != 0) begin
          if (act_cnt == AC_W'(ACTIVE_CYCLES - 1)) begin
            state_d     = IDLE;
            act_cnt_d   = '0;
            match_cnt_d = '0;
            hist_clr    = 1'b1;
          end else begin
            act_cnt_d = act_cnt + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef TROJAN_SEQ_DBG_EN
    if (dbg_disarm) begin
      state_d     = IDLE;
      match_cnt_d = '0;
      act_cnt_d   = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      match_cnt <= '0;
      act_cnt   <= '0;
      payload   <= '0;
      active    <= 1'b0;
    end else begin
      state     <= state_d;
      match_cnt <= match_cnt_d;
      act_cnt   <= act_cnt_d;
      payload   <= (state == ACTIVE) ? (key ^ FLIP_MASK) : key;
      active    <= (state_d == ACTIVE);
    end
  end

`ifdef TROJAN_SEQ_DBG_EN
  assign dbg_match_cnt = match_cnt;
  assign dbg_hist      = hist;
`else
  logic unused_hist;
  assign unused_hist = ^hist;
`endif

endmodule

// File: tb/tb_trojan_seq_param.sv
// Bench for trojan_seq_param: three parameter sets driven in lock-step against a queue-based reference model.
// Covers TROJAN_SEQ_DBG_EN disarm when that macro is defined.
module tb_trojan_seq_param;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        trig_valid = 1'b0;
  logic        dis = 1'b0;
  logic [55:0] key = '0;
  logic [31:0] trigger = '0;
  logic [55:0] pay [3];
  logic        act [3];
  logic [0:0]  dbg_mc0, dbg_mc2;
  logic [1:0]  dbg_mc1;
  logic [5:0]  dbg_h [3];

  int n_tests = 0;
  int n_fail  = 0;

  localparam int          THR [3] = '{1, 2, 1};
  localparam int          WIN [3] = '{0, 0, 4};
  localparam logic [55:0] MSK [3] = '{56'h1, 56'h1, 56'hFF};
  int tgt [3] = '{2, 1, 3};

  int          hq [3][$];
  int          m_cnt [3];
  int          m_left [3];
  bit          m_act [3];
  bit          fresh;
  logic [55:0] e_pay [3];
  logic        e_act [3];

  always #5 clk = ~clk;

  trojan_seq_param u_def (
    .clk(clk), .rst(rst), .key(key), .trigger(trigger), .trig_valid(trig_valid),
    .payload(pay[0]),
`ifdef TROJAN_SEQ_DBG_EN
    .dbg_disarm(dis), .dbg_match_cnt(dbg_mc0), .dbg_hist(dbg_h[0]),
`endif
    .active(act[0]));

  trojan_seq_param #(.COUNT_THRESH(2)) u_cnt (
    .clk(clk), .rst(rst), .key(key), .trigger(trigger), .trig_valid(trig_valid),
    .payload(pay[1]),
`ifdef TROJAN_SEQ_DBG_EN
    .dbg_disarm(dis), .dbg_match_cnt(dbg_mc1), .dbg_hist(dbg_h[1]),
`endif
    .active(act[1]));

  trojan_seq_param #(.ACTIVE_CYCLES(4), .FLIP_MASK(56'hFF)) u_win (
    .clk(clk), .rst(rst), .key(key), .trigger(trigger), .trig_valid(trig_valid),
    .payload(pay[2]),
`ifdef TROJAN_SEQ_DBG_EN
    .dbg_disarm(dis), .dbg_match_cnt(dbg_mc2), .dbg_hist(dbg_h[2]),
`endif
    .active(act[2]));

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      hq[c].delete();
      m_cnt[c]  = 0;
      m_left[c] = 0;
      m_act[c]  = 1'b0;
      e_pay[c]  = '0;
      e_act[c]  = 1'b0;
    end
    fresh = 1'b0;
  endtask

  // Advance one clock edge, update the reference model, return 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      bit m;
      bit expire;
      m = fresh && hq[c].size() == 3 &&
          hq[c][0] == tgt[0] && hq[c][1] == tgt[1] && hq[c][2] == tgt[2];
      e_pay[c] = m_act[c] ? (key ^ MSK[c]) : key;
      expire = 1'b0;
      if (dis) begin
        m_act[c] = 1'b0;
        m_cnt[c] = 0;
      end else if (m_act[c]) begin
        if (WIN[c] > 0) begin
          m_left[c]--;
          if (m_left[c] == 0) begin
            m_act[c] = 1'b0;
            m_cnt[c] = 0;
            expire   = 1'b1;
          end
        end
      end else if (m) begin
        m_cnt[c]++;
        if (m_cnt[c] == THR[c]) begin
          m_act[c]  = 1'b1;
          m_cnt[c]  = 0;
          m_left[c] = WIN[c];
        end
      end
      e_act[c] = m_act[c];
      if (expire) hq[c].delete();
      else if (trig_valid) begin
        hq[c].push_back(int'(trigger[1:0]));
        if (hq[c].size() > 3) void'(hq[c].pop_front());
      end
    end
    fresh = trig_valid;
    #1;
  endtask

  task automatic drive(input bit v, input int s);
    trig_valid   = v;
    trigger      = $urandom();
    trigger[1:0] = s[1:0];
  endtask

  task automatic send3(input int a, input int b, input int c);
    drive(1'b1, a); tick();
    drive(1'b1, b); tick();
    drive(1'b1, c); tick();
    drive(1'b0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    trig_valid = 1'b0;
    dis = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    for (int c = 0; c < 3; c++) begin
      n_tests++;
      if (pay[c] !== 56'h0 || act[c] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset inst%0d: payload=%h active=%b, want 0/0", c, pay[c], act[c]);
      end
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    do_reset();
    key = 56'hA5;
    send3(2, 1, 3);
    n_tests++;
    if (act[0] !== 1'b0) begin
      n_fail++; $display("FAIL basic_e0 active=%b want 0", act[0]);
    end
    tick();
    n_tests++;
    if (act[0] !== 1'b1 || pay[0] !== 56'hA5) begin
      n_fail++; $display("FAIL basic_e1 active=%b payload=%h want 1/a5", act[0], pay[0]);
    end
    tick();
    n_tests++;
    if (pay[0] !== 56'hA4) begin
      n_fail++; $display("FAIL basic_e2 payload=%h want a4", pay[0]);
    end
    for (int i = 0; i < 1000; i++) begin
      drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      tick();
      n_tests++;
      if (pay[0] !== 56'hA4 || act[0] !== 1'b1) begin
        n_fail++; $display("FAIL basic_hold cyc%0d payload=%h active=%b want a4/1", i, pay[0], act[0]);
      end
    end
    drive(1'b0, 0);
  endtask

  task automatic test_gaps();
    do_reset();
    key = {$urandom(), $urandom()};
    drive(1'b1, 2); tick();
    drive(1'b0, 3); tick(); tick();
    drive(1'b1, 1); tick();
    drive(1'b0, 2); tick();
    drive(1'b1, 3); tick();
    drive(1'b0, 0); tick();
    n_tests++;
    if (act[0] !== 1'b1 || e_act[0] !== 1'b1) begin
      n_fail++; $display("FAIL gaps active=%b want 1", act[0]);
    end
  endtask

  task automatic test_no_match();
    int syms [7] = '{2, 3, 1, 2, 1, 1, 3};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      key = {$urandom(), $urandom()};
      drive(1'b1, syms[i]);
      tick();
    end
    drive(1'b0, 0);
    for (int i = 0; i < 5; i++) begin
      key = {$urandom(), $urandom()};
      tick();
      n_tests++;
      if (pay[0] !== key || act[0] !== 1'b0) begin
        n_fail++; $display("FAIL nomatch cyc%0d payload=%h active=%b want %h/0", i, pay[0], act[0], key);
      end
    end
  endtask

  task automatic test_thresh();
    do_reset();
    key = {$urandom(), $urandom()};
    send3(2, 1, 3);
    tick(); tick(); tick();
    n_tests++;
    if (act[1] !== 1'b0 || pay[1] !== key) begin
      n_fail++; $display("FAIL thresh_first active=%b payload=%h want 0/%h", act[1], pay[1], key);
    end
    send3(2, 1, 3);
    tick();
    n_tests++;
    if (act[1] !== 1'b1) begin
      n_fail++; $display("FAIL thresh_second active=%b want 1", act[1]);
    end
    tick();
    n_tests++;
    if (pay[1] !== (key ^ 56'h1)) begin
      n_fail++; $display("FAIL thresh_payload payload=%h want %h", pay[1], key ^ 56'h1);
    end
  endtask

  task automatic test_window();
    int hits;
    do_reset();
    key = '0;
    for (int rep = 0; rep < 2; rep++) begin
      send3(2, 1, 3);
      hits = 0;
      for (int i = 0; i < 12; i++) begin
        tick();
        if (pay[2] == 56'hFF) hits++;
        n_tests++;
        if (pay[2] !== e_pay[2] || act[2] !== e_act[2]) begin
          n_fail++;
          $display("FAIL window rep%0d cyc%0d payload=%h active=%b want %h/%b",
                   rep, i, pay[2], act[2], e_pay[2], e_act[2]);
        end
      end
      n_tests++;
      if (hits != 4 || pay[2] !== 56'h0) begin
        n_fail++; $display("FAIL window_len rep%0d corrupted=%0d last=%h want 4/0", rep, hits, pay[2]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    key = {$urandom(), $urandom()};
    send3(2, 1, 3);
    tick(); tick();
    #2 rst = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      n_tests++;
      if (pay[c] !== 56'h0 || act[c] !== 1'b0) begin
        n_fail++; $display("FAIL reset_mid inst%0d payload=%h active=%b want 0/0", c, pay[c], act[c]);
      end
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      key = {$urandom(), $urandom()};
      tick();
      n_tests++;
      if (pay[0] !== key || act[0] !== 1'b0) begin
        n_fail++; $display("FAIL post_reset cyc%0d payload=%h active=%b want %h/0", i, pay[0], act[0], key);
      end
    end
  endtask

  task automatic test_random();
    int pend [$];
    for (int i = 0; i < 3000; i++) begin
      if (i % 600 == 0) do_reset();
      if (pend.size() == 0 && $urandom_range(0, 15) == 0) pend = '{2, 1, 3};
      key = {$urandom(), $urandom()};
      if (pend.size() != 0 && $urandom_range(0, 3) != 0) drive(1'b1, pend.pop_front());
      else drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      tick();
      for (int c = 0; c < 3; c++) begin
        n_tests++;
        if (pay[c] !== e_pay[c] || act[c] !== e_act[c]) begin
          n_fail++;
          $display("FAIL random cyc%0d inst%0d payload=%h active=%b want %h/%b",
                   i, c, pay[c], act[c], e_pay[c], e_act[c]);
        end
      end
    end
    drive(1'b0, 0);
  endtask

`ifdef TROJAN_SEQ_DBG_EN
  task automatic test_disarm();
    do_reset();
    key = {$urandom(), $urandom()};
    send3(2, 1, 3);
    tick(); tick();
    n_tests++;
    if (act[0] !== 1'b1) begin
      n_fail++; $display("FAIL disarm_pre active=%b want 1", act[0]);
    end
    dis = 1'b1;
    tick();
    dis = 1'b0;
    n_tests++;
    if (act[0] !== 1'b0 || dbg_mc0 !== 1'b0 || e_act[0] !== 1'b0) begin
      n_fail++; $display("FAIL disarm active=%b match_cnt=%0d want 0/0", act[0], dbg_mc0);
    end
    tick();
    n_tests++;
    if (pay[0] !== key) begin
      n_fail++; $display("FAIL disarm_payload payload=%h want %h", pay[0], key);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_gaps();
    test_no_match();
    test_thresh();
    test_window();
    test_reset_mid();
    test_random();
`ifdef TROJAN_SEQ_DBG_EN
    test_disarm();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
